// File: rtl/mio_wb_decoder.sv
// rtl/mio_wb_decoder.sv - Wishbone-classic MIO decoder/bridge to NSLV slaves; optional watchdog via `define MIO_TIMEOUT_EN
module mio_wb_decoder #(
  parameter int            NSLV     = 4,
  parameter logic [NSLV*32-1:0] BASE = {NSLV{32'h0}},
  parameter logic [NSLV*32-1:0] MASK = {NSLV{32'h0}},
  parameter int            TIMEOUT  = 16,
  parameter logic [31:0]   ERR_DATA = 32'hDEADBEEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        dat_i,
  input  logic [31:0]        adr_i,
  input  logic               we_i,
  input  logic               stb_i,
  output logic [31:0]        dat_o,
  output logic               ack_o,
  output logic               err_o,
  output logic [NSLV-1:0]    s_stb_o,
  output logic               s_we_o,
  output logic [31:0]        s_adr_o,
  output logic [31:0]        s_dat_o,
  input  logic [NSLV*32-1:0] s_dat_i,
  input  logic [NSLV-1:0]    s_ack_i
);

  localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [SW-1:0] sel;
  logic [SW-1:0] hit_idx;
  logic          hit;
  logic          ack_sel;
  logic          wdog_expire;

  // Address decode: scan from the top so the lowest matching window wins
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((adr_i & MASK[32*i +: 32]) == BASE[32*i +: 32]) begin
        hit     = 1'b1;
        hit_idx = SW'(i);
      end
    end
  end

  assign ack_sel = s_ack_i[sel];

`ifdef MIO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wdog;

  assign wdog_expire = (wdog == TW'(TIMEOUT - 1));

  // Watchdog counts REQ cycles; cleared whenever REQ is left
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog <= '0;
    end else if (state == REQ && state_next == REQ) begin
      wdog <= wdog + 1'b1;
    end else begin
      wdog <= '0;
    end
  end
`else
  assign wdog_expire = 1'b0;
`endif

  // Next-state logic; a slave ack beats a simultaneous watchdog expiry
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (stb_i) state_next = hit ? REQ : ERR;
      REQ: begin
        if (ack_sel) begin
          state_next = RESP;
        end else if (wdog_expire) begin
          state_next = ERR;
        end
      end
      RESP:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request latch and read-data capture; dat_o is loaded on entry to RESP/ERR so it is valid with the pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel     <= '0;
      s_we_o  <= 1'b0;
      s_adr_o <= '0;
      s_dat_o <= '0;
      dat_o   <= '0;
    end else begin
      if (state == IDLE && stb_i) begin
        s_adr_o <= adr_i;
        s_dat_o <= dat_i;
        s_we_o  <= we_i;
        sel     <= hit_idx;
        if (!hit && !we_i) dat_o <= ERR_DATA;
      end
      if (state == REQ && !s_we_o) begin
        if (ack_sel) begin
          dat_o <= s_dat_i[32*sel +: 32];
        end else if (wdog_expire) begin
          dat_o <= ERR_DATA;
        end
      end
    end
  end

  // Slave strobe is one-hot on the latched index while in REQ, zero otherwise
  always_comb begin
    s_stb_o = '0;
    for (int i = 0; i < NSLV; i++) begin
      s_stb_o[i] = (state == REQ) && (sel == SW'(i));
    end
  end

  assign ack_o = (state == RESP);
  assign err_o = (state == ERR);

endmodule
